// File: rtl/hazard_stall_unit_pkg.sv
// Shared pipeline-control definitions: FSM encoding, register width and the
// canned control bundles driven onto the pipeline-register enables.
package hazard_stall_unit_pkg;

    localparam int PIPE_REG_W = 4;

    typedef enum logic [1:0] {
        RUN     = 2'b00,
        BR_WAIT = 2'b01,
        HALTED  = 2'b10
    } hz_state_e;

    typedef struct packed {
        logic pcWriteEn;
        logic ifidWriteEn;
        logic ifidFlush;
        logic idexBubble;
        logic exmemWriteEn;
        logic memwbBubble;
    } pipe_ctrl_t;

    // NOP bundle: every stage is bubbled or held, as during reset.
    localparam pipe_ctrl_t CTRL_NOP = '{
        pcWriteEn: 1'b0, ifidWriteEn: 1'b0, ifidFlush: 1'b1,
        idexBubble: 1'b1, exmemWriteEn: 1'b0, memwbBubble: 1'b1
    };

    localparam pipe_ctrl_t CTRL_GO = '{
        pcWriteEn: 1'b1, ifidWriteEn: 1'b1, ifidFlush: 1'b0,
        idexBubble: 1'b0, exmemWriteEn: 1'b1, memwbBubble: 1'b0
    };

    // Front end held, a bubble enters EX, the back end keeps moving.
    localparam pipe_ctrl_t CTRL_STALL = '{
        pcWriteEn: 1'b0, ifidWriteEn: 1'b0, ifidFlush: 1'b0,
        idexBubble: 1'b1, exmemWriteEn: 1'b1, memwbBubble: 1'b0
    };

    // Data memory busy: everything upstream of MEM/WB stands still.
    localparam pipe_ctrl_t CTRL_FREEZE = '{
        pcWriteEn: 1'b0, ifidWriteEn: 1'b0, ifidFlush: 1'b0,
        idexBubble: 1'b0, exmemWriteEn: 1'b0, memwbBubble: 1'b1
    };

    localparam pipe_ctrl_t CTRL_FLUSH = '{
        pcWriteEn: 1'b1, ifidWriteEn: 1'b1, ifidFlush: 1'b1,
        idexBubble: 1'b0, exmemWriteEn: 1'b1, memwbBubble: 1'b0
    };

    // HLT leaves ID into EX while fetch stops.
    localparam pipe_ctrl_t CTRL_HLT_ISSUE = '{
        pcWriteEn: 1'b0, ifidWriteEn: 1'b0, ifidFlush: 1'b0,
        idexBubble: 1'b0, exmemWriteEn: 1'b1, memwbBubble: 1'b0
    };

    // Cycles an ID-resolved branch must wait for its rs operand.
    function automatic logic [1:0] branch_need(input logic exHit,
                                               input logic exIsLoad,
                                               input logic memLoadHit);
        if (exHit && exIsLoad)
            return 2'd2;
        else if (exHit || memLoadHit)
            return 2'd1;
        else
            return 2'd0;
    endfunction

endpackage

// File: rtl/hazard_stall_unit_reg_match.sv
// Destination-vs-sources comparator with write qualification; register 0
// never matches because it is hard-wired to zero.
module hazard_stall_unit_reg_match #(
    parameter int W = 4
) (
    input  logic [W-1:0]      dst,
    input  logic              dstWrites,
    input  logic [1:0][W-1:0] src,
    input  logic [1:0]        srcUsed,
    output logic              hit
);

    logic [1:0] srcHit;

    generate
        for (genvar gi = 0; gi < 2; gi++) begin : g_src
            assign srcHit[gi] = srcUsed[gi] && (dst == src[gi]);
        end
    endgenerate

    assign hit = dstWrites && (dst != '0) && (|srcHit);

endmodule

// File: rtl/hazard_stall_unit.sv
// ID-stage hazard/stall control: load-use and branch-operand stalls, taken-branch
// flush, memory-busy freeze and HLT drain, plus a saturating stall counter.
module hazard_stall_unit
    import hazard_stall_unit_pkg::*;
#(
    parameter int REG_W = PIPE_REG_W,
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [REG_W-1:0] SrcReg1_IFID,
    input  logic [REG_W-1:0] SrcReg2_IFID,
    input  logic             Src1_used_IFID,
    input  logic             Src2_used_IFID,
    input  logic             Branch_IFID,
    input  logic             Branch_taken_ID,
    input  logic             Halt_IFID,
    input  logic [REG_W-1:0] DstReg_IDEX,
    input  logic             RegWrite_IDEX,
    input  logic             MemRead_IDEX,
    input  logic [REG_W-1:0] DstReg_EXMEM,
    input  logic             MemRead_EXMEM,
    input  logic             mem_stall,
    output logic             PC_write_en,
    output logic             IFID_write_en,
    output logic             IFID_flush,
    output logic             IDEX_bubble,
    output logic             EXMEM_write_en,
    output logic             MEMWB_bubble,
    output logic             halted,
    output logic [CNT_W-1:0] stall_count
);

    localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

    hz_state_e        stateReg, stateNext;
    logic [1:0]       brCntReg, brCntNext;
    logic [CNT_W-1:0] stallCountReg;

    logic       luHit, exBrHit, memBrHit;
    logic [1:0] brNeed;
    pipe_ctrl_t ctrl, ctrlOut;
    logic       countEn;

    hazard_stall_unit_reg_match #(.W(REG_W)) u_lu_match (
        .dst       (DstReg_IDEX),
        .dstWrites (MemRead_IDEX & RegWrite_IDEX),
        .src       ({SrcReg2_IFID, SrcReg1_IFID}),
        .srcUsed   ({Src2_used_IFID, Src1_used_IFID}),
        .hit       (luHit)
    );

    // Branches compare rs only; srcUsed gates the match with Branch_IFID.
    hazard_stall_unit_reg_match #(.W(REG_W)) u_ex_br_match (
        .dst       (DstReg_IDEX),
        .dstWrites (RegWrite_IDEX),
        .src       ({SrcReg2_IFID, SrcReg1_IFID}),
        .srcUsed   ({1'b0, Branch_IFID}),
        .hit       (exBrHit)
    );

    hazard_stall_unit_reg_match #(.W(REG_W)) u_mem_br_match (
        .dst       (DstReg_EXMEM),
        .dstWrites (MemRead_EXMEM),
        .src       ({SrcReg2_IFID, SrcReg1_IFID}),
        .srcUsed   ({1'b0, Branch_IFID}),
        .hit       (memBrHit)
    );

    assign brNeed = branch_need(exBrHit, MemRead_IDEX, memBrHit);

    always_comb begin
        ctrl      = CTRL_GO;
        stateNext = stateReg;
        brCntNext = brCntReg;
        if (mem_stall) begin
            ctrl = CTRL_FREEZE;
        end else begin
            case (stateReg)
                RUN: begin
                    if (luHit) begin
                        ctrl = CTRL_STALL;
                    end else if (brNeed != 2'd0) begin
                        ctrl      = CTRL_STALL;
                        brCntNext = brNeed - 2'd1;
                        if (brNeed > 2'd1)
                            stateNext = BR_WAIT;
                    end else if (Branch_IFID && Branch_taken_ID) begin
                        ctrl = CTRL_FLUSH;
                    end else if (Halt_IFID) begin
                        ctrl      = CTRL_HLT_ISSUE;
                        stateNext = HALTED;
                    end
                end
                BR_WAIT: begin
                    ctrl = CTRL_STALL;
                    if (brCntReg <= 2'd1) begin
                        brCntNext = 2'd0;
                        stateNext = RUN;
                    end else begin
                        brCntNext = brCntReg - 2'd1;
                    end
                end
                HALTED: begin
                    ctrl = CTRL_STALL;
                end
                default: begin
                    ctrl      = CTRL_STALL;
                    brCntNext = 2'd0;
                    stateNext = RUN;
                end
            endcase
        end
    end

    // Halt drain cycles are excluded; only RUN/BR_WAIT front-end holds count.
    assign countEn = !ctrl.pcWriteEn && ((stateReg == RUN) || (stateReg == BR_WAIT));

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            stateReg      <= RUN;
            brCntReg      <= 2'd0;
            stallCountReg <= '0;
        end else begin
            stateReg <= stateNext;
            brCntReg <= brCntNext;
            if (countEn && (stallCountReg != '1))
                stallCountReg <= stallCountReg + CNT_ONE;
        end
    end

    assign ctrlOut        = rst ? CTRL_NOP : ctrl;
    assign PC_write_en    = ctrlOut.pcWriteEn;
    assign IFID_write_en  = ctrlOut.ifidWriteEn;
    assign IFID_flush     = ctrlOut.ifidFlush;
    assign IDEX_bubble    = ctrlOut.idexBubble;
    assign EXMEM_write_en = ctrlOut.exmemWriteEn;
    assign MEMWB_bubble   = ctrlOut.memwbBubble;
    assign halted         = !rst && (stateReg == HALTED);
    assign stall_count    = stallCountReg;

endmodule

// File: tb/tb_hazard_stall_unit.sv
// Scoreboard bench for hazard_stall_unit: each cycle pushes the expected
// control vector and stall count, then pops and compares mid-cycle.
module tb_hazard_stall_unit;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [3:0]  SrcReg1_IFID, SrcReg2_IFID, DstReg_IDEX, DstReg_EXMEM;
    logic        Src1_used_IFID, Src2_used_IFID, Branch_IFID, Branch_taken_ID, Halt_IFID;
    logic        RegWrite_IDEX, MemRead_IDEX, MemRead_EXMEM, mem_stall;
    logic        PC_write_en, IFID_write_en, IFID_flush, IDEX_bubble;
    logic        EXMEM_write_en, MEMWB_bubble, halted;
    logic [15:0] stall_count;

    // Control vector order: {PC, IFID_we, IFID_flush, IDEX_bubble, EXMEM_we, MEMWB_bubble, halted}
    localparam logic [6:0] C_RESET  = 7'b0011010;
    localparam logic [6:0] C_FREE   = 7'b1100100;
    localparam logic [6:0] C_STALL  = 7'b0001100;
    localparam logic [6:0] C_FLUSH  = 7'b1110100;
    localparam logic [6:0] C_FREEZE = 7'b0000010;
    localparam logic [6:0] C_HLTRUN = 7'b0000100;
    localparam logic [6:0] C_HALTED = 7'b0001101;
    localparam logic [6:0] C_HALTFZ = 7'b0000011;

    typedef struct packed {
        logic [3:0] s1;
        logic [3:0] s2;
        logic [4:0] flags;   // {u1, u2, br, tk, hlt}
        logic [3:0] dEx;
        logic [1:0] ex;      // {RegWrite_IDEX, MemRead_IDEX}
        logic [3:0] dMem;
        logic [1:0] misc;    // {MemRead_EXMEM, mem_stall}
    } stim_t;

    typedef struct packed {
        logic [6:0]  ctrl;
        logic [15:0] cnt;
    } exp_t;

    exp_t sbq[$];
    int   checks = 0;
    int   errors = 0;

    always #5 clk = ~clk;

    hazard_stall_unit #(.REG_W(4), .CNT_W(16)) dut (
        .clk             (clk),
        .rst             (rst),
        .SrcReg1_IFID    (SrcReg1_IFID),
        .SrcReg2_IFID    (SrcReg2_IFID),
        .Src1_used_IFID  (Src1_used_IFID),
        .Src2_used_IFID  (Src2_used_IFID),
        .Branch_IFID     (Branch_IFID),
        .Branch_taken_ID (Branch_taken_ID),
        .Halt_IFID       (Halt_IFID),
        .DstReg_IDEX     (DstReg_IDEX),
        .RegWrite_IDEX   (RegWrite_IDEX),
        .MemRead_IDEX    (MemRead_IDEX),
        .DstReg_EXMEM    (DstReg_EXMEM),
        .MemRead_EXMEM   (MemRead_EXMEM),
        .mem_stall       (mem_stall),
        .PC_write_en     (PC_write_en),
        .IFID_write_en   (IFID_write_en),
        .IFID_flush      (IFID_flush),
        .IDEX_bubble     (IDEX_bubble),
        .EXMEM_write_en  (EXMEM_write_en),
        .MEMWB_bubble    (MEMWB_bubble),
        .halted          (halted),
        .stall_count     (stall_count)
    );

    function automatic stim_t mk(input logic [3:0] s1, input logic [3:0] s2,
                                 input logic [4:0] flags, input logic [3:0] dEx,
                                 input logic [1:0] ex, input logic [3:0] dMem,
                                 input logic [1:0] misc);
        stim_t s;
        s = '{s1, s2, flags, dEx, ex, dMem, misc};
        return s;
    endfunction

    function automatic logic [6:0] obs_ctrl();
        return {PC_write_en, IFID_write_en, IFID_flush, IDEX_bubble,
                EXMEM_write_en, MEMWB_bubble, halted};
    endfunction

    task automatic set_in(input stim_t s);
        SrcReg1_IFID    = s.s1;
        SrcReg2_IFID    = s.s2;
        Src1_used_IFID  = s.flags[4];
        Src2_used_IFID  = s.flags[3];
        Branch_IFID     = s.flags[2];
        Branch_taken_ID = s.flags[1];
        Halt_IFID       = s.flags[0];
        DstReg_IDEX     = s.dEx;
        RegWrite_IDEX   = s.ex[1];
        MemRead_IDEX    = s.ex[0];
        DstReg_EXMEM    = s.dMem;
        MemRead_EXMEM   = s.misc[1];
        mem_stall       = s.misc[0];
    endtask

    task automatic drive(input stim_t s, input logic [6:0] ec, input logic [15:0] cnt);
        set_in(s);
        sbq.push_back('{ctrl: ec, cnt: cnt});
    endtask

    task automatic apply_reset();
        rst = 1'b1;
        set_in(mk(4'd0, 4'd0, 5'b0, 4'd0, 2'b00, 4'd0, 2'b00));
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
    endtask

    task automatic test_reset();
        exp_t e;
        rst = 1'b1;
        set_in(mk(4'd3, 4'd2, 5'b11001, 4'd3, 2'b11, 4'd0, 2'b01));
        for (int i = 0; i < 2; i++) begin
            sbq.push_back('{ctrl: C_RESET, cnt: 16'd0});
            @(negedge clk);
            e = sbq.pop_front();
            checks++;
            if (obs_ctrl() !== e.ctrl) begin
                errors++;
                $display("FAIL reset ctrl cyc%0d: got %b expected %b", i, obs_ctrl(), e.ctrl);
            end
            checks++;
            if (stall_count !== e.cnt) begin
                errors++;
                $display("FAIL reset cnt cyc%0d: got %0d expected %0d", i, stall_count, e.cnt);
            end
            $display("reset      cyc%0d ctrl=%b cnt=%0d", i, obs_ctrl(), stall_count);
        end
    endtask

    task automatic test_load_use();
        stim_t sv[3]; logic [6:0] ec[3]; logic [15:0] en[3]; exp_t e;
        apply_reset();
        sv[0] = mk(4'd3, 4'd2, 5'b11000, 4'd3, 2'b11, 4'd0, 2'b00); ec[0] = C_STALL; en[0] = 16'd0;
        sv[1] = mk(4'd3, 4'd2, 5'b11000, 4'd0, 2'b00, 4'd3, 2'b10); ec[1] = C_FREE;  en[1] = 16'd1;
        sv[2] = mk(4'd7, 4'd8, 5'b11000, 4'd5, 2'b10, 4'd0, 2'b00); ec[2] = C_FREE;  en[2] = 16'd1;
        for (int i = 0; i < 3; i++) begin
            drive(sv[i], ec[i], en[i]);
            @(negedge clk);
            e = sbq.pop_front();
            checks++;
            if (obs_ctrl() !== e.ctrl) begin
                errors++;
                $display("FAIL load_use ctrl cyc%0d: got %b expected %b", i, obs_ctrl(), e.ctrl);
            end
            checks++;
            if (stall_count !== e.cnt) begin
                errors++;
                $display("FAIL load_use cnt cyc%0d: got %0d expected %0d", i, stall_count, e.cnt);
            end
            $display("load_use   cyc%0d ctrl=%b cnt=%0d", i, obs_ctrl(), stall_count);
            @(posedge clk); #1;
        end
    endtask

    task automatic test_zero_reg();
        stim_t sv[3]; exp_t e;
        apply_reset();
        sv[0] = mk(4'd0, 4'd2, 5'b11000, 4'd0, 2'b11, 4'd0, 2'b00);
        sv[1] = mk(4'd5, 4'd7, 5'b10000, 4'd7, 2'b11, 4'd0, 2'b00);
        sv[2] = mk(4'd0, 4'd0, 5'b10100, 4'd0, 2'b10, 4'd0, 2'b10);
        for (int i = 0; i < 3; i++) begin
            drive(sv[i], C_FREE, 16'd0);
            @(negedge clk);
            e = sbq.pop_front();
            checks++;
            if (obs_ctrl() !== e.ctrl) begin
                errors++;
                $display("FAIL zero_reg ctrl cyc%0d: got %b expected %b", i, obs_ctrl(), e.ctrl);
            end
            checks++;
            if (stall_count !== e.cnt) begin
                errors++;
                $display("FAIL zero_reg cnt cyc%0d: got %0d expected %0d", i, stall_count, e.cnt);
            end
            $display("zero_reg   cyc%0d ctrl=%b cnt=%0d", i, obs_ctrl(), stall_count);
            @(posedge clk); #1;
        end
    endtask

    task automatic test_branch_load();
        stim_t sv[4]; logic [6:0] ec[4]; logic [15:0] en[4]; exp_t e;
        apply_reset();
        sv[0] = mk(4'd4, 4'd0, 5'b00110, 4'd4, 2'b11, 4'd0, 2'b00); ec[0] = C_STALL; en[0] = 16'd0;
        sv[1] = mk(4'd4, 4'd0, 5'b00110, 4'd0, 2'b00, 4'd4, 2'b10); ec[1] = C_STALL; en[1] = 16'd1;
        sv[2] = mk(4'd4, 4'd0, 5'b00110, 4'd0, 2'b00, 4'd0, 2'b00); ec[2] = C_FLUSH; en[2] = 16'd2;
        sv[3] = mk(4'd1, 4'd2, 5'b11000, 4'd0, 2'b00, 4'd0, 2'b00); ec[3] = C_FREE;  en[3] = 16'd2;
        for (int i = 0; i < 4; i++) begin
            drive(sv[i], ec[i], en[i]);
            @(negedge clk);
            e = sbq.pop_front();
            checks++;
            if (obs_ctrl() !== e.ctrl) begin
                errors++;
                $display("FAIL branch_load ctrl cyc%0d: got %b expected %b", i, obs_ctrl(), e.ctrl);
            end
            checks++;
            if (stall_count !== e.cnt) begin
                errors++;
                $display("FAIL branch_load cnt cyc%0d: got %0d expected %0d", i, stall_count, e.cnt);
            end
            $display("branch_ld  cyc%0d ctrl=%b cnt=%0d", i, obs_ctrl(), stall_count);
            @(posedge clk); #1;
        end
    endtask

    task automatic test_branch_alu();
        stim_t sv[3]; logic [6:0] ec[3]; logic [15:0] en[3]; exp_t e;
        apply_reset();
        sv[0] = mk(4'd6, 4'd0, 5'b10100, 4'd6, 2'b10, 4'd0, 2'b00); ec[0] = C_STALL; en[0] = 16'd0;
        sv[1] = mk(4'd6, 4'd0, 5'b10100, 4'd0, 2'b00, 4'd6, 2'b00); ec[1] = C_FREE;  en[1] = 16'd1;
        sv[2] = mk(4'd2, 4'd3, 5'b11000, 4'd0, 2'b00, 4'd0, 2'b00); ec[2] = C_FREE;  en[2] = 16'd1;
        for (int i = 0; i < 3; i++) begin
            drive(sv[i], ec[i], en[i]);
            @(negedge clk);
            e = sbq.pop_front();
            checks++;
            if (obs_ctrl() !== e.ctrl) begin
                errors++;
                $display("FAIL branch_alu ctrl cyc%0d: got %b expected %b", i, obs_ctrl(), e.ctrl);
            end
            checks++;
            if (stall_count !== e.cnt) begin
                errors++;
                $display("FAIL branch_alu cnt cyc%0d: got %0d expected %0d", i, stall_count, e.cnt);
            end
            $display("branch_alu cyc%0d ctrl=%b cnt=%0d", i, obs_ctrl(), stall_count);
            @(posedge clk); #1;
        end
    endtask

    task automatic test_mem_stall();
        stim_t sv[6]; logic [6:0] ec[6]; logic [15:0] en[6]; exp_t e;
        apply_reset();
        sv[0] = mk(4'd4, 4'd0, 5'b00100, 4'd4, 2'b11, 4'd0, 2'b00); ec[0] = C_STALL; en[0] = 16'd0;
        for (int k = 1; k <= 3; k++) begin
            sv[k] = mk(4'd4, 4'd0, 5'b00100, 4'd0, 2'b00, 4'd4, 2'b11);
            ec[k] = C_FREEZE;
            en[k] = 16'(k);
        end
        sv[4] = mk(4'd4, 4'd0, 5'b00100, 4'd0, 2'b00, 4'd4, 2'b10); ec[4] = C_STALL; en[4] = 16'd4;
        sv[5] = mk(4'd1, 4'd2, 5'b11000, 4'd0, 2'b00, 4'd0, 2'b00); ec[5] = C_FREE;  en[5] = 16'd5;
        for (int i = 0; i < 6; i++) begin
            drive(sv[i], ec[i], en[i]);
            @(negedge clk);
            e = sbq.pop_front();
            checks++;
            if (obs_ctrl() !== e.ctrl) begin
                errors++;
                $display("FAIL mem_stall ctrl cyc%0d: got %b expected %b", i, obs_ctrl(), e.ctrl);
            end
            checks++;
            if (stall_count !== e.cnt) begin
                errors++;
                $display("FAIL mem_stall cnt cyc%0d: got %0d expected %0d", i, stall_count, e.cnt);
            end
            $display("mem_stall  cyc%0d ctrl=%b cnt=%0d", i, obs_ctrl(), stall_count);
            @(posedge clk); #1;
        end
    endtask

    task automatic test_halt();
        stim_t sv[4]; logic [6:0] ec[4]; logic [15:0] en[4]; exp_t e;
        apply_reset();
        sv[0] = mk(4'd0, 4'd0, 5'b00001, 4'd0, 2'b00, 4'd0, 2'b00); ec[0] = C_HLTRUN; en[0] = 16'd0;
        sv[1] = mk(4'd0, 4'd0, 5'b00001, 4'd0, 2'b00, 4'd0, 2'b00); ec[1] = C_HALTED; en[1] = 16'd1;
        sv[2] = mk(4'd0, 4'd0, 5'b00001, 4'd0, 2'b00, 4'd0, 2'b01); ec[2] = C_HALTFZ; en[2] = 16'd1;
        sv[3] = mk(4'd3, 4'd0, 5'b10110, 4'd3, 2'b11, 4'd0, 2'b00); ec[3] = C_HALTED; en[3] = 16'd1;
        for (int i = 0; i < 4; i++) begin
            drive(sv[i], ec[i], en[i]);
            @(negedge clk);
            e = sbq.pop_front();
            checks++;
            if (obs_ctrl() !== e.ctrl) begin
                errors++;
                $display("FAIL halt ctrl cyc%0d: got %b expected %b", i, obs_ctrl(), e.ctrl);
            end
            checks++;
            if (stall_count !== e.cnt) begin
                errors++;
                $display("FAIL halt cnt cyc%0d: got %0d expected %0d", i, stall_count, e.cnt);
            end
            $display("halt       cyc%0d ctrl=%b cnt=%0d", i, obs_ctrl(), stall_count);
            @(posedge clk); #1;
        end
    endtask

    task automatic test_reset_midstall();
        stim_t sv[4]; logic [6:0] ec[4]; logic [15:0] en[4]; exp_t e;
        apply_reset();
        sv[0] = mk(4'd4, 4'd0, 5'b00100, 4'd4, 2'b11, 4'd0, 2'b00); ec[0] = C_STALL; en[0] = 16'd0;
        sv[1] = mk(4'd4, 4'd0, 5'b00100, 4'd0, 2'b00, 4'd4, 2'b10); ec[1] = C_RESET; en[1] = 16'd0;
        sv[2] = mk(4'd1, 4'd2, 5'b11000, 4'd0, 2'b00, 4'd0, 2'b00); ec[2] = C_FREE;  en[2] = 16'd0;
        sv[3] = mk(4'd5, 4'd0, 5'b00110, 4'd0, 2'b00, 4'd0, 2'b00); ec[3] = C_FLUSH; en[3] = 16'd0;
        for (int i = 0; i < 4; i++) begin
            drive(sv[i], ec[i], en[i]);
            // Second entry: reset asserted asynchronously while in BR_WAIT.
            if (i == 1) begin
                rst = 1'b1;
                #2;
            end else begin
                @(negedge clk);
            end
            e = sbq.pop_front();
            checks++;
            if (obs_ctrl() !== e.ctrl) begin
                errors++;
                $display("FAIL rst_mid ctrl cyc%0d: got %b expected %b", i, obs_ctrl(), e.ctrl);
            end
            checks++;
            if (stall_count !== e.cnt) begin
                errors++;
                $display("FAIL rst_mid cnt cyc%0d: got %0d expected %0d", i, stall_count, e.cnt);
            end
            $display("rst_mid    cyc%0d ctrl=%b cnt=%0d", i, obs_ctrl(), stall_count);
            @(posedge clk); #1;
            rst = 1'b0;
        end
    endtask

    task automatic test_saturation();
        exp_t e;
        apply_reset();
        for (int i = 0; i < 2; i++) begin
            drive(mk(4'd0, 4'd0, 5'b0, 4'd0, 2'b00, 4'd0, 2'b01), C_FREEZE, 16'hFFFF);
            if (i == 0)
                repeat (65540) @(posedge clk);
            @(negedge clk);
            e = sbq.pop_front();
            checks++;
            if (obs_ctrl() !== e.ctrl) begin
                errors++;
                $display("FAIL saturate ctrl cyc%0d: got %b expected %b", i, obs_ctrl(), e.ctrl);
            end
            checks++;
            if (stall_count !== e.cnt) begin
                errors++;
                $display("FAIL saturate cnt cyc%0d: got %0d expected %0d", i, stall_count, e.cnt);
            end
            $display("saturate   cyc%0d ctrl=%b cnt=%0d", i, obs_ctrl(), stall_count);
            @(posedge clk); #1;
        end
    endtask

    initial begin
        test_reset();
        test_load_use();
        test_zero_reg();
        test_branch_load();
        test_branch_alu();
        test_mem_stall();
        test_halt();
        test_reset_midstall();
        test_saturation();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
